// File: rtl/bm_encode_pkg.sv
// Shared constants and types for the bm_case_encode slice.
// Optional feature macro: BM_ENCODE_PRIORITY_EN (multi-hot -> lowest set index).
package bm_encode_pkg;

  localparam int unsigned BITS_DEFAULT = 2;
  localparam int unsigned FIFO_DEPTH   = 2;
  localparam int unsigned ERR_CNT_W    = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = 4'd15;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  // Input vector width for a given code width.
  function automatic int unsigned vec_width(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/bm_onehot_enc.sv
// Combinational one-hot to binary encoder with an "unencodable" flag.
// Optional feature macro: BM_ENCODE_PRIORITY_EN (multi-hot -> lowest set index).
module bm_onehot_enc
  import bm_encode_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic [vec_width(BITS)-1:0] in_vec,
  output logic [BITS-1:0]            code,
  output logic                       err
);

  localparam int unsigned N = vec_width(BITS);

  logic found;

`ifdef BM_ENCODE_PRIORITY_EN
  // Lowest set bit wins; only an all-zero vector is an error.
  always_comb begin
    code  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_vec[i] && !found) begin
        code  = BITS'(i);
        found = 1'b1;
      end
    end
    err = !found;
  end
`else
  logic multi;

  // Exactly one set bit encodes; zero or multi-hot reports code 0 with err.
  always_comb begin
    code  = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        if (!found) begin
          code  = BITS'(i);
          found = 1'b1;
        end else begin
          multi = 1'b1;
        end
      end
    end
    err = !found || multi;
    if (multi) begin
      code = '0;
    end
  end
`endif

endmodule

// File: rtl/bm_case_encode.sv
// Encoder with valid/ready handshakes, 2-entry result FIFO and a saturating
// error counter. Optional feature macro: BM_ENCODE_PRIORITY_EN.
module bm_case_encode
  import bm_encode_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [vec_width(BITS)-1:0] in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BITS-1:0]            out_code,
  output logic                       out_err,
  output logic [ERR_CNT_W-1:0]       err_count
);

  occ_t            occ;
  logic [BITS-1:0] code_q [FIFO_DEPTH];
  logic            err_q  [FIFO_DEPTH];

  logic [BITS-1:0] enc_code;
  logic            enc_err;
  logic            push;
  logic            pop;

  bm_onehot_enc #(.BITS(BITS)) u_enc (
    .in_vec (in_vec),
    .code   (enc_code),
    .err    (enc_err)
  );

  // Handshake qualification; entry 0 is always the FIFO head.
  always_comb begin
    out_valid = (occ != OCC_EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_code  = code_q[0];
    out_err   = err_q[0];
  end

  // Occupancy FSM, FIFO storage, registered in_ready and error counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ       <= OCC_EMPTY;
      in_ready  <= 1'b0;
      code_q    <= '{default: '0};
      err_q     <= '{default: 1'b0};
      err_count <= '0;
    end else begin
      // in_ready is set to (next occupancy != FULL) in every branch.
      unique case (occ)
        OCC_EMPTY: begin
          if (push) begin
            code_q[0] <= enc_code;
            err_q[0]  <= enc_err;
            occ       <= OCC_ONE;
          end
          in_ready <= 1'b1;
        end
        OCC_ONE: begin
          if (push && pop) begin
            code_q[0] <= enc_code;
            err_q[0]  <= enc_err;
            in_ready  <= 1'b1;
          end else if (push) begin
            code_q[1] <= enc_code;
            err_q[1]  <= enc_err;
            occ       <= OCC_FULL;
            in_ready  <= 1'b0;
          end else if (pop) begin
            occ      <= OCC_EMPTY;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b1;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            code_q[0] <= code_q[1];
            err_q[0]  <= err_q[1];
            occ       <= OCC_ONE;
            in_ready  <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          occ      <= OCC_EMPTY;
          in_ready <= 1'b1;
        end
      endcase

      if (push && enc_err && (err_count != ERR_CNT_SAT)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
